// File: rtl/uart_case_fifo_if.sv
// Purpose: handshake/status bundle between a UART receiver/transmitter pair
//          and the case-converting FIFO.
// Ports (slave = FIFO side):
//   in : i_data, i_valid, i_mode, i_flush, i_ready
//   out: o_data, o_valid, o_count, o_empty, o_full, o_almostfull, o_rts,
//        o_drop_cnt
interface uart_case_fifo_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic [1:0]       i_mode;
    logic             i_flush;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic [CW-1:0]    o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_almostfull;
    logic             o_rts;
    logic [CNT_W-1:0] o_drop_cnt;

    modport slave (
        input  i_data, i_valid, i_mode, i_flush, i_ready,
        output o_data, o_valid, o_count, o_empty, o_full, o_almostfull,
               o_rts, o_drop_cnt
    );

    modport master (
        output i_data, i_valid, i_mode, i_flush, i_ready,
        input  o_data, o_valid, o_count, o_empty, o_full, o_almostfull,
               o_rts, o_drop_cnt
    );
endinterface

// File: rtl/uart_case_fifo.sv
// Purpose: first-word-fall-through FIFO between a UART receiver and
//          transmitter that applies ASCII case conversion at write time,
//          with occupancy flags, RTS flow control and an overflow counter.
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      asynchronous active-high reset
//   bus        uart_case_fifo_if.slave (data in/out, handshake, status)
module uart_case_fifo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ALMOST_FULL = 12,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_case_fifo_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q;
    logic             empty_q;
    logic             full_q;
    logic             afull_q;
    logic             rts_q;

    logic             push_c;
    logic             pop_c;
    logic [WIDTH-1:0] wdata_c;

    // Case conversion on the low byte only; upper bits pass through.
    function automatic logic [WIDTH-1:0] convert(input logic [WIDTH-1:0] d,
                                                 input logic [1:0]       mode);
        logic [WIDTH-1:0] r;
        logic [7:0]       lo;
        r  = d;
        lo = d[7:0];
        if (mode[0] && lo >= 8'h61 && lo <= 8'h7A) r[7:0] = lo - 8'h20;
        if (mode[1] && lo >= 8'h41 && lo <= 8'h5A) r[7:0] = lo + 8'h20;
        return r;
    endfunction

    // Handshake decode; flush overrides both directions.
    always_comb begin
        pop_c   = valid_q && bus.i_ready && !bus.i_flush;
        push_c  = bus.i_valid && !bus.i_flush && (!full_q || pop_c);
        wdata_c = convert(bus.i_data, bus.i_mode);
    end

    // Next-state for pointers, occupancy, drop counter and head register.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        drop_d  = drop_q;
        data_d  = data_q;

        if (bus.i_flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_c) wr_d = wr_q + PTR_W'(1);
            if (pop_c)  rd_d = rd_q + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.i_valid && full_q && !pop_c && drop_q != {CNT_W{1'b1}})
                drop_d = drop_q + CNT_W'(1);
        end

        // Head after this edge: the new byte if it lands on the read slot.
        if (count_d == '0)
            data_d = '0;
        else if (push_c && rd_d == wr_q)
            data_d = wdata_c;
        else
            data_d = mem_q[rd_d];
    end

    // Storage array: no reset, contents are qualified by occupancy.
    always_ff @(posedge i_clk) begin
        if (push_c) mem_q[wr_q] <= wdata_c;
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            drop_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            rts_q   <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            valid_q <= (count_d != '0);
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
            afull_q <= (count_d >= CW'(ALMOST_FULL));
            rts_q   <= (count_d <  CW'(ALMOST_FULL));
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_count      = count_q;
    assign bus.o_empty      = empty_q;
    assign bus.o_full       = full_q;
    assign bus.o_almostfull = afull_q;
    assign bus.o_rts        = rts_q;
    assign bus.o_drop_cnt   = drop_q;
endmodule

// File: tb/tb_uart_case_fifo.sv
module tb_uart_case_fifo;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned CNT_W = 8;
    localparam int          DROP_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    logic chk_en;
    int   total;
    int   bad;

    uart_case_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    uart_case_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF), .CNT_W(CNT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of stored bytes plus a drop count.
    logic [7:0] exp_q[$];
    int         exp_drop;

    function automatic logic [7:0] ref_conv(input logic [7:0] c, input logic [1:0] m);
        bit is_lower;
        bit is_upper;
        is_lower = (c >= "a") && (c <= "z");
        is_upper = (c >= "A") && (c <= "Z");
        case (m)
            2'b01:   return is_lower ? c - 8'd32 : c;
            2'b10:   return is_upper ? c + 8'd32 : c;
            2'b11:   return is_lower ? c - 8'd32 : (is_upper ? c + 8'd32 : c);
            default: return c;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_drop = 0;
        end else if (bus.i_flush) begin
            exp_q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (exp_q.size() > 0) && bus.i_ready;
            do_push = bus.i_valid && ((exp_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(ref_conv(bus.i_data, bus.i_mode));
            if (bus.i_valid && !do_push && exp_drop < DROP_MAX) exp_drop++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int n;
            n = exp_q.size();
            chk("valid", 32'(bus.o_valid), 32'(n > 0));
            chk("data",  32'(bus.o_data),  (n > 0) ? 32'(exp_q[0]) : 32'd0);
            chk("count", 32'(bus.o_count), 32'(n));
            chk("empty", 32'(bus.o_empty), 32'(n == 0));
            chk("full",  32'(bus.o_full),  32'(n == DEPTH));
            chk("afull", 32'(bus.o_almostfull), 32'(n >= AF));
            chk("rts",   32'(bus.o_rts),   32'(n < AF));
            chk("drop",  32'(bus.o_drop_cnt), 32'(exp_drop));
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m,
                         input logic r, input logic f);
        @(negedge clk);
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_mode  = m;
        bus.i_ready = r;
        bus.i_flush = f;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        chk({tag, "_data"},  32'(bus.o_data),  32'd0);
        chk({tag, "_count"}, 32'(bus.o_count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
        chk({tag, "_full"},  32'(bus.o_full),  32'd0);
        chk({tag, "_afull"}, 32'(bus.o_almostfull), 32'd0);
        chk({tag, "_rts"},   32'(bus.o_rts),   32'd1);
        chk({tag, "_drop"},  32'(bus.o_drop_cnt), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_mode  = 2'b00;
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b0;
        #1;
        chk_reset_vals("por");
        #12 rst = 1'b0;
        chk_en = 1'b1;

        // Upper-case mode, transmitter always ready.
        drive(1, "a", 2'b01, 1, 0);
        drive(1, "Z", 2'b01, 1, 0);  chk("up_a", 32'(bus.o_data), 32'h41);
        drive(1, "{", 2'b01, 1, 0);  chk("up_Z", 32'(bus.o_data), 32'h5A);
        drive(1, "m", 2'b01, 1, 0);  chk("up_brace", 32'(bus.o_data), 32'h7B);
        drive(0, 8'h00, 2'b00, 1, 0); chk("up_m", 32'(bus.o_data), 32'h4D);
        drive(0, 8'h00, 2'b00, 1, 0); chk("up_done", 32'(bus.o_valid), 32'd0);

        // Mode change after write does not alter the stored byte.
        drive(1, "q", 2'b11, 0, 0);
        drive(0, 8'h00, 2'b00, 0, 0); chk("tog_q", 32'(bus.o_data), 32'h51);
        drive(0, 8'h00, 2'b00, 1, 0);
        drive(0, 8'h00, 2'b00, 0, 0); chk("tog_empty", 32'(bus.o_empty), 32'd1);

        // Fill to full then overflow by three.
        for (int i = 0; i < 19; i++) begin
            drive(1, 8'(8'h30 + i), 2'b00, 0, 0);
            if (i == 11) chk("fill11_afull", 32'(bus.o_almostfull), 32'd0);
            if (i == 12) begin
                chk("fill12_afull", 32'(bus.o_almostfull), 32'd1);
                chk("fill12_rts",   32'(bus.o_rts), 32'd0);
            end
            if (i == 15) chk("fill15_full", 32'(bus.o_full), 32'd0);
            if (i == 16) chk("fill16_full", 32'(bus.o_full), 32'd1);
        end
        // Push and pop together while full.
        drive(1, 8'h55, 2'b00, 1, 0); chk("ovf_drop", 32'(bus.o_drop_cnt), 32'd3);
        drive(0, 8'h00, 2'b00, 0, 0);
        chk("pp_count", 32'(bus.o_count), 32'd16);
        chk("pp_drop",  32'(bus.o_drop_cnt), 32'd3);
        chk("pp_head",  32'(bus.o_data), 32'h31);
        for (int i = 0; i < 16; i++) begin
            drive(0, 8'h00, 2'b00, 1, 0);
            chk("drain", 32'(bus.o_data), (i < 15) ? 32'(8'h31 + i) : 32'h55);
        end
        drive(0, 8'h00, 2'b00, 0, 0); chk("drained", 32'(bus.o_empty), 32'd1);

        // Flush with five entries and coincident valid/ready.
        for (int i = 0; i < 5; i++) drive(1, 8'(8'h61 + i), 2'b10, 0, 0);
        drive(1, 8'h77, 2'b00, 1, 1);
        drive(0, 8'h00, 2'b00, 0, 0);
        chk("fl_count", 32'(bus.o_count), 32'd0);
        chk("fl_valid", 32'(bus.o_valid), 32'd0);
        chk("fl_data",  32'(bus.o_data),  32'd0);
        chk("fl_drop",  32'(bus.o_drop_cnt), 32'd3);

        // Drop counter saturation.
        for (int i = 0; i < DEPTH + DROP_MAX + 5; i++)
            drive(1, 8'($urandom), 2'($urandom), 0, 0);
        drive(0, 8'h00, 2'b00, 0, 0);
        chk("sat_drop", 32'(bus.o_drop_cnt), 32'(DROP_MAX));
        drive(0, 8'h00, 2'b00, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(8'h40, 8'h7F)) : 8'($urandom);
            drive(($urandom_range(0, 9) < 6), d, 2'($urandom),
                  ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 8)),
                  ($urandom_range(0, 99) < 2));
        end

        // Asynchronous reset between edges with data in flight.
        for (int i = 0; i < 4; i++) drive(1, 8'(8'h41 + i), 2'b00, 0, 0);
        #2 rst = 1'b1;
        #1 chk_reset_vals("arst");
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h61;
        bus.i_mode  = 2'b01;
        bus.i_ready = 1'b0;
        bus.i_flush = 1'b0;
        #1 rst = 1'b0;
        drive(0, 8'h00, 2'b00, 0, 0);
        chk("post_rst_data",  32'(bus.o_data),  32'h41);
        chk("post_rst_count", 32'(bus.o_count), 32'd1);
        drive(0, 8'h00, 2'b00, 1, 0);
        drive(0, 8'h00, 2'b00, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_case_fifo.md
UART_CASE_FIFO -- requirements
Module: uart_case_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; SHALL be >= 8.
REQ-002 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of 2 and >= 2.
REQ-003 Parameter ALMOST_FULL, default 12: occupancy threshold for o_almostfull; SHALL satisfy 1 <= ALMOST_FULL <= DEPTH.
REQ-004 Parameter CNT_W, default 8: width of the drop counter.
REQ-005 Clocking and reset SHALL be one clock, with an asynchronous, active-high reset.
REQ-006 i_clk  in  1  system clock; all state updates on the rising edge.
REQ-007 i_rst  in  1  asynchronous active-high reset.
REQ-008 i_data  in  WIDTH  received byte from the UART receiver.
REQ-009 i_valid  in  1  single-cycle strobe; i_data is valid this cycle.
REQ-010 i_mode  in  2  conversion mode: 00 pass, 01 upper, 10 lower, 11 toggle case.
REQ-011 i_flush  in  1  synchronous clear of FIFO contents.
REQ-012 o_data  out  WIDTH  head-of-FIFO data toward the UART transmitter.
REQ-013 o_valid  out  1  head entry is present.
REQ-014 i_ready  in  1  transmitter accepts o_data this cycle.
REQ-015 o_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-016 o_empty, o_full, o_almostfull  out  1 each  status flags.
REQ-017 o_rts  out  1  flow-control request-to-send to the far end; equals ~o_almostfull.
REQ-018 o_drop_cnt  out  CNT_W  count of bytes lost to overflow.

Function
REQ-019 Conversion SHALL be applied at write time, using i_mode sampled in the write cycle; a later i_mode change SHALL NOT alter stored entries.
REQ-020 Conversion SHALL examine only bits [7:0]; bits [WIDTH-1:8] SHALL pass unchanged.
- upper: 0x61-0x7A minus 0x20.
- lower: 0x41-0x5A plus 0x20.
- toggle: both rules apply.
- All other values are unchanged in every mode.
REQ-021 Push condition: push = i_valid && !i_flush && (!o_full || pop).
REQ-022 Pop condition: pop = o_valid && i_ready && !i_flush.
REQ-023 Head behaviour: the FIFO SHALL be first-word-fall-through.
- o_valid = !o_empty.
- o_data SHALL be the oldest entry.
- o_data SHALL be all-zero whenever o_valid=0.
REQ-024 Write-to-output latency SHALL be 1 cycle: a byte pushed at edge N into an empty FIFO is shown on o_data/o_valid after edge N, with no same-cycle bypass.
REQ-025 Ordering: entries SHALL leave in arrival order.
REQ-026 Pointers: read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Occupancy: o_count SHALL change by +1 on push only, -1 on pop only, and 0 on push and pop together.
REQ-028 Simultaneous push and pop while full SHALL be accepted, leaving o_count = DEPTH.
REQ-029 Simultaneous push and pop while empty SHALL be impossible (pop requires o_valid); the push alone is taken.
REQ-030 Flag definitions:
- o_full = (o_count == DEPTH).
- o_empty = (o_count == 0).
- o_almostfull = (o_count >= ALMOST_FULL).
- All flags SHALL be derived from registered state, with no combinational path from i_valid or i_ready.
REQ-031 Overflow: i_valid && o_full && !pop && !i_flush SHALL drop the byte and increment o_drop_cnt, saturating at 2^CNT_W-1.
REQ-032 Flush: i_flush=1 SHALL set o_count to 0 and reset both pointers at the next edge.
- It SHALL ignore any coincident push or pop.
- A coincident i_valid SHALL NOT count as a drop.
- o_drop_cnt SHALL be preserved.
REQ-033 Protocol: o_data SHALL remain stable while o_valid=1 and i_ready=0.

Reset
REQ-034 On i_rst assertion, independent of i_clk, outputs SHALL immediately take:
- o_valid=0, o_data=0, o_count=0, o_empty=1.
- o_full=0, o_almostfull=0, o_rts=1, o_drop_cnt=0.
REQ-035 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-036 After i_rst deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-037 Mode 01: send "a","Z","{","m" with i_ready=1 -> output "A","Z","{","M" in order, each 1 cycle after its push.
REQ-038 Mode change: send "q" in mode 11, then switch to 00 before it is read -> output "Q".
REQ-039 Fill and overflow (DEPTH=16, i_ready=0): push 0x30..0x3F, then 3 more bytes:
- After byte 12: o_almostfull=1, o_rts=0.
- After byte 16: o_full=1.
- o_drop_cnt ends at 3.
- Draining yields 0x30..0x3F only.
REQ-040 Full with simultaneous push and pop: o_count stays 16, drop counter does not increment, the new byte is emitted last.
REQ-041 Flush: with 5 entries, assert i_flush together with i_valid and i_ready -> next cycle o_count=0, o_valid=0, o_data=0, o_drop_cnt unchanged.
REQ-042 Async reset: assert i_rst mid-stream between clock edges -> all outputs take REQ-034 values before the next edge; a post-reset push of 0x61 in mode 01 emits 0x41.
